// File: rtl/instr_prefetch_queue_if.sv
// rtl/instr_prefetch_queue_if.sv - fetch/decode handshake bundle for the instruction prefetch queue
interface instr_prefetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  OP;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  // Queue side: issues fetches, presents the head instruction to decode
  modport master (
    output imem_req, imem_addr, instr, instr_pc, OP, instr_valid,
    input  imem_data, imem_valid, instr_ready, redirect, redirect_pc
  );

  // Environment side: instruction memory plus decode/branch unit
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, OP, instr_valid,
    output imem_data, imem_valid, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - instruction prefetch queue with a single outstanding fetch
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input logic                    clk,
  input logic                    reset,
  instr_prefetch_queue_if.master bus
);
  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0]      PC_INIT = {RESET_PC[31:2], 2'b00};

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [31:0]      pc_mem_q   [DEPTH];
  logic [31:0]      word_mem_q [DEPTH];

  logic             issue;
  logic             push;
  logic             pop;
  logic             head_valid;
  logic [CNT_W-1:0] credit;
  logic             unused_pc_bits;

  // Byte offset of a redirect target is meaningless for word fetches
  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  // Slots already spoken for: stored entries plus the one in flight
  assign credit     = count_q + CNT_W'(pending_q);
  assign head_valid = (count_q != '0);
  assign issue      = reset && !bus.redirect && (credit < DEPTH_C);
  assign push       = pending_q && bus.imem_valid && !bus.redirect;
  assign pop        = head_valid && bus.instr_ready && !bus.redirect;

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_valid ? word_mem_q[head_q] : '0;
  assign bus.instr_pc    = head_valid ? pc_mem_q[head_q] : '0;
  assign bus.OP          = head_valid ? word_mem_q[head_q][31:26] : '0;

  // Next-state: redirect flushes everything; otherwise issue, push and pop
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    pending_d  = pending_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      pending_d  = 1'b0;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        req_addr_d = fetch_pc_q;
        pending_d  = 1'b1;
      end else if (push) begin
        pending_d = 1'b0;
      end
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state, cleared asynchronously so a mid-run reset drops everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= PC_INIT;
      req_addr_q <= '0;
      pending_q  <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Entry storage; contents are only visible through a valid head so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]   <= req_addr_q;
      word_mem_q[tail_q] <= bus.imem_data;
    end
  end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - directed self-checking bench for instr_prefetch_queue
module tb_instr_prefetch_queue;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk;
  logic reset;
  instr_prefetch_queue_if bus ();

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        mem_en;
  logic [31:0] mem_xor;
  logic        mem_req_s;
  logic [31:0] mem_addr_s;
  logic [31:0] req_log [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request observer and one-cycle-latency memory returning word = address ^ mem_xor
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.imem_req === 1'b1) req_log.push_back(bus.imem_addr);
    mem_req_s  = bus.imem_req;
    mem_addr_s = bus.imem_addr;
  end

  always @(posedge clk) begin
    #1;
    if (mem_en) begin
      bus.imem_valid = mem_req_s;
      bus.imem_data  = mem_addr_s ^ mem_xor;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    req_log.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", bus.instr_valid); end
    n_cmp++; if (bus.instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr got %h want 0", bus.instr); end
    n_cmp++; if (bus.instr_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc got %h want 0", bus.instr_pc); end
    n_cmp++; if (bus.OP !== 6'h0) begin n_bad++; $display("FAIL rst_op got %h want 0", bus.OP); end
  endtask

  task automatic test_stream();
    mem_en = 1'b1; mem_xor = '0; bus.instr_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_bad++; $display("FAIL stream_first_req got %b want 1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== RST_PC) begin n_bad++; $display("FAIL stream_first_addr got %h want %h", bus.imem_addr, RST_PC); end
      end
      n_cmp++; if (bus.instr_valid !== (c >= 2)) begin n_bad++; $display("FAIL stream_valid c%0d got %b want %b", c, bus.instr_valid, c >= 2); end
      if (c >= 2) begin
        n_cmp++; if (bus.instr_pc !== RST_PC + 32'(4 * (c - 2))) begin n_bad++; $display("FAIL stream_pc c%0d got %h want %h", c, bus.instr_pc, RST_PC + 32'(4 * (c - 2))); end
        n_cmp++; if (bus.instr !== RST_PC + 32'(4 * (c - 2))) begin n_bad++; $display("FAIL stream_word c%0d got %h want %h", c, bus.instr, RST_PC + 32'(4 * (c - 2))); end
      end
    end
  endtask

  task automatic test_full();
    logic [31:0] exp;
    mem_en = 1'b1; mem_xor = '0; bus.instr_ready = 1'b0;
    do_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_log.size() !== 4) begin n_bad++; $display("FAIL full_nreq got %0d want 4", req_log.size()); end
    for (int i = 0; i < 4; i++) begin
      exp = RST_PC + 32'(4 * i);
      n_cmp++; if (i >= req_log.size() || req_log[i] !== exp) begin n_bad++; $display("FAIL full_req%0d got %h want %h", i, (i < req_log.size()) ? req_log[i] : 32'hx, exp); end
    end
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL full_req_idle got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.instr_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid got %b want 1", bus.instr_valid); end
    n_cmp++; if (bus.instr_pc !== RST_PC) begin n_bad++; $display("FAIL full_head got %h want %h", bus.instr_pc, RST_PC); end
  endtask

  task automatic test_pulse();
    logic [31:0] exp;
    int          n;
    @(posedge clk); #1;
    req_log.delete();
    bus.instr_ready = 1'b1;
    @(posedge clk); #1;
    bus.instr_ready = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_log.size() !== 1) begin n_bad++; $display("FAIL pulse_nreq got %0d want 1", req_log.size()); end
    n_cmp++; if (req_log.size() == 0 || req_log[0] !== 32'h0040_0010) begin n_bad++; $display("FAIL pulse_addr got %h want 00400010", (req_log.size() > 0) ? req_log[0] : 32'hx); end
    n_cmp++; if (bus.instr_pc !== 32'h0040_0004) begin n_bad++; $display("FAIL pulse_head got %h want 00400004", bus.instr_pc); end
    @(posedge clk); #1;
    bus.instr_ready = 1'b1;
    exp = 32'h0040_0004;
    n = 0;
    for (int k = 0; k < 30 && n < 6; k++) begin
      @(negedge clk);
      if (bus.instr_valid === 1'b1) begin
        n_cmp++; if (bus.instr_pc !== exp || bus.instr !== exp) begin n_bad++; $display("FAIL drain_seq got pc %h word %h want %h", bus.instr_pc, bus.instr, exp); end
        exp = exp + 32'd4;
        n++;
      end
    end
    n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL drain_count got %0d want 6", n); end
  endtask

  task automatic test_redirect();
    mem_en = 1'b1; mem_xor = '0; bus.instr_ready = 1'b1;
    do_reset();
    repeat (3) begin @(posedge clk); #1; end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0040_0103;
    @(negedge clk);
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL redir_req_gate got %b want 0", bus.imem_req); end
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    req_log.delete();
    @(negedge clk);
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0100) begin n_bad++; $display("FAIL redir_addr got req %b addr %h want 1 00400100", bus.imem_req, bus.imem_addr); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_bubble1 got %b want 0", bus.instr_valid); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_bubble2 got %b want 0", bus.instr_valid); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0040_0100) begin n_bad++; $display("FAIL redir_first got valid %b pc %h want 1 00400100", bus.instr_valid, bus.instr_pc); end
    n_cmp++; if (bus.instr !== 32'h0040_0100) begin n_bad++; $display("FAIL redir_word got %h want 00400100", bus.instr); end
  endtask

  task automatic test_redirect_collide();
    mem_en = 1'b0; bus.imem_valid = 1'b0; bus.imem_data = '0; bus.instr_ready = 1'b0;
    do_reset();
    @(posedge clk); #1;
    bus.imem_valid = 1'b1; bus.imem_data = 32'hFC00_0001;
    @(posedge clk); #1;
    bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h0050_0000;
    bus.imem_valid = 1'b1; bus.imem_data = 32'hFC00_0002;
    @(negedge clk);
    n_cmp++; if (bus.OP !== 6'h3F || bus.instr !== 32'hFC00_0001) begin n_bad++; $display("FAIL coll_head got op %h word %h want 3f fc000001", bus.OP, bus.instr); end
    n_cmp++; if (bus.instr_pc !== RST_PC) begin n_bad++; $display("FAIL coll_head_pc got %h want %h", bus.instr_pc, RST_PC); end
    @(posedge clk); #1;
    bus.redirect = 1'b0; bus.imem_valid = 1'b1; bus.imem_data = 32'hFC00_0003;
    @(negedge clk);
    n_cmp++; if (bus.instr_valid !== 1'b0 || bus.OP !== 6'h0 || bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin n_bad++; $display("FAIL coll_flush got valid %b op %h word %h pc %h want 0 0 0 0", bus.instr_valid, bus.OP, bus.instr, bus.instr_pc); end
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0050_0000) begin n_bad++; $display("FAIL coll_refetch got req %b addr %h want 1 00500000", bus.imem_req, bus.imem_addr); end
    @(posedge clk); #1;
    bus.imem_valid = 1'b1; bus.imem_data = 32'h0C00_0000;
    @(negedge clk);
    n_cmp++; if (bus.instr_valid !== 1'b0 || bus.OP !== 6'h0) begin n_bad++; $display("FAIL coll_stale got valid %b op %h want 0 0", bus.instr_valid, bus.OP); end
    @(posedge clk); #1;
    bus.imem_valid = 1'b0; bus.instr_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0050_0000) begin n_bad++; $display("FAIL coll_new got valid %b pc %h want 1 00500000", bus.instr_valid, bus.instr_pc); end
    n_cmp++; if (bus.OP !== 6'h03 || bus.instr !== 32'h0C00_0000) begin n_bad++; $display("FAIL coll_new_op got op %h word %h want 03 0c000000", bus.OP, bus.instr); end
    mem_en = 1'b1;
  endtask

  task automatic test_wrap_reset();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
    mem_en = 1'b1; mem_xor = '0; bus.instr_ready = 1'b1;
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    req_log.delete();
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (i >= req_log.size() || req_log[i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_req%0d got %h want %h", i, (i < req_log.size()) ? req_log[i] : 32'hx, exp_a[i]); end
    end
    n_cmp++; if (bus.instr_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_pre_valid got %b want 1", bus.instr_valid); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.OP !== 6'h0) begin n_bad++; $display("FAIL async_ctl got req %b valid %b op %h want 0 0 0", bus.imem_req, bus.instr_valid, bus.OP); end
    n_cmp++; if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin n_bad++; $display("FAIL async_data got word %h pc %h want 0 0", bus.instr, bus.instr_pc); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    req_log.delete();
    @(negedge clk);
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin n_bad++; $display("FAIL post_rst_req got req %b addr %h want 1 %h", bus.imem_req, bus.imem_addr, RST_PC); end
    repeat (2) begin @(posedge clk); @(negedge clk); end
    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== RST_PC) begin n_bad++; $display("FAIL post_rst_head got valid %b pc %h want 1 %h", bus.instr_valid, bus.instr_pc, RST_PC); end
  endtask

  initial begin
    reset = 1'b0;
    mem_en = 1'b1;
    mem_xor = '0;
    mem_req_s = 1'b0;
    mem_addr_s = '0;
    bus.imem_valid = 1'b0;
    bus.imem_data = '0;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    test_reset();
    test_stream();
    test_full();
    test_pulse();
    test_redirect();
    test_redirect_collide();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    n_bad++;
    $display("FAIL watchdog got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 4, giving the number of queue entries (power of two, minimum 2).
REQ-002 The block SHALL have a parameter RESET_PC, default 32'h0040_0000, giving the first fetch address after reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-006 Port imem_addr, output, 32 bits: fetch address, word-aligned.
REQ-007 Port imem_data, input, 32 bits: fetched instruction word.
REQ-008 Port imem_valid, input, 1 bit: imem_data is valid for the request issued in the previous cycle.
REQ-009 Port instr, output, 32 bits: head-of-queue instruction.
REQ-010 Port instr_pc, output, 32 bits: address of instr.
REQ-011 Port OP, output, 6 bits: instr[31:26] when instr_valid is high, else 6'h00; feeds the Control decoder.
REQ-012 Port instr_valid, output, 1 bit: the queue head is valid.
REQ-013 Port instr_ready, input, 1 bit: decode consumes the head this cycle.
REQ-014 Port redirect, input, 1 bit: jump or taken branch; flush and refetch.
REQ-015 Port redirect_pc, input, 32 bits: new fetch address, valid with redirect.

Function
REQ-016 The block SHALL hold fetch_pc, a queue of DEPTH {pc, word} entries, a count of 0..DEPTH, and a 1-bit pending flag for the one outstanding request.
REQ-017 imem_addr SHALL equal fetch_pc; bits [1:0] SHALL always be 0, and redirect_pc[1:0] SHALL be ignored.
REQ-018 imem_req SHALL be high, combinationally, exactly when (count + pending) < DEPTH and redirect is low.
REQ-019 On an edge with imem_req high: pending <= 1, the issued address is recorded, and fetch_pc <= fetch_pc + 4, with 32-bit wrap from 32'hFFFF_FFFC to 0.
REQ-020 Memory latency SHALL be fixed at one cycle; at most one request SHALL be outstanding.
REQ-021 On an edge with imem_valid high and pending high, {recorded address, imem_data} SHALL be pushed at the tail and pending SHALL clear unless a new request issues on the same edge.
REQ-022 imem_valid with pending low SHALL be ignored.
REQ-023 Pop: on an edge with instr_valid and instr_ready both high, the head SHALL advance.
REQ-024 Push and pop on the same edge SHALL leave count unchanged; the credit rule in REQ-018 SHALL guarantee that no push occurs when the queue is full.
REQ-025 Empty: instr_valid SHALL be 0, instr and instr_pc SHALL be 0, and instr_ready SHALL be ignored.
REQ-026 Redirect has top priority; on an edge with redirect high: count <= 0, pending <= 0, fetch_pc <= {redirect_pc[31:2], 2'b00}, and any same-cycle pop or push SHALL be discarded.
REQ-027 After a redirect, the response to a request issued before the redirect SHALL never enter the queue, including when it returns in the cycle right after the redirect.
REQ-028 The first instruction at a new fetch_pc SHALL appear: request in cycle N, imem_valid in N+1, instr_valid in N+2.
REQ-029 Head and tail pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 While reset is low, the block SHALL set fetch_pc = RESET_PC, count = 0, pending = 0 and pointers = 0, and SHALL drive imem_req = 0, instr = 0, instr_pc = 0, OP = 0 and instr_valid = 0.
REQ-031 Assertion of reset mid-operation SHALL discard queue contents and the outstanding request immediately.
REQ-032 After reset release, imem_req SHALL rise in the first cycle, with imem_addr = RESET_PC.

Verification
REQ-033 Reset release with instr_ready held at 1 and memory returning word = address -> instr_pc sequence 0x00400000, 0x00400004, ...; first instr_valid 2 cycles after the first request; one instruction per cycle thereafter.
REQ-034 instr_ready held at 0 -> exactly 4 requests issued (0x00400000 to 0x0040000C); imem_req then stays 0; count = 4; the head stays 0x00400000.
REQ-035 Full queue, then instr_ready pulsed for 1 cycle -> exactly one new request, for 0x00400010; no overflow and no lost word.
REQ-036 Redirect to 0x00400103 while a request is outstanding -> the stale response is dropped; the next request is to 0x00400100; instr_valid is 0 for 2 cycles, then instr_pc = 0x00400100.
REQ-037 Redirect, pop and imem_valid on the same edge -> queue empty; no stale entry appears; OP = 0 while invalid.
REQ-038 Redirect to 0xFFFFFFF8 -> fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; reset asserted mid-stream -> all outputs 0 asynchronously; after release, refetch starts from 0x00400000.
